// File: rtl/mux_2.sv
// 4-to-1 lane mux with a combinational output and an enabled, asynchronously cleared register copy.
// Optional even-parity register on the captured lane: define MUX_2_PARITY_EN.
module mux_2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       sel,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [1:0]       sel_q
`ifdef MUX_2_PARITY_EN
    ,
    output logic             par_q
`endif
);

    logic [WIDTH-1:0] w_out;
    logic [WIDTH-1:0] r_out_q;
    logic [1:0]       r_sel_q;

    // An unknown select matches no arm, so load data falls to zero instead of X.
    always_comb begin
        w_out = '0;
        case (sel)
            2'b00:   w_out = in0;
            2'b01:   w_out = in1;
            2'b10:   w_out = in2;
            2'b11:   w_out = in3;
            default: w_out = '0;
        endcase
    end

    assign out = w_out;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_out_q <= '0;
            r_sel_q <= 2'b00;
        end else if (en) begin
            r_out_q <= w_out;
            r_sel_q <= sel;
        end
    end

    assign out_q = r_out_q;
    assign sel_q = r_sel_q;

`ifdef MUX_2_PARITY_EN
    logic r_par_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_par_q <= 1'b0;
        end else if (en) begin
            r_par_q <= ^w_out;
        end
    end

    assign par_q = r_par_q;
`endif

endmodule

// File: tb/tb_mux_2.sv
// Scoreboard bench for mux_2: stimulus pushes expected values, a monitor samples and compares.
module tb_mux_2;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] in0, in1, in2, in3;
    logic [1:0] sel;
    logic       en;
    logic [7:0] out, out_q;
    logic [1:0] sel_q;
`ifdef MUX_2_PARITY_EN
    logic       par_q;
`endif

    mux_2 #(.WIDTH(8)) dut (
        .clk   (clk),
        .clr   (clr),
        .in0   (in0),
        .in1   (in1),
        .in2   (in2),
        .in3   (in3),
        .sel   (sel),
        .en    (en),
        .out   (out),
        .out_q (out_q),
        .sel_q (sel_q)
`ifdef MUX_2_PARITY_EN
        ,
        .par_q (par_q)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         chk_out;
        logic [7:0] e_out;
        bit         chk_q;
        logic [7:0] e_out_q;
        logic [1:0] e_sel_q;
        bit         chk_par;
        logic       e_par;
    } exp_t;

    exp_t sb[$];
    event ev_push;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Monitor: samples the DUT 1 time unit after each push, away from clock edges.
    initial begin
        exp_t e;
        forever begin
            @(ev_push);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk_out) begin
                    n_tests++;
                    if (out !== e.e_out) begin
                        n_fail++;
                        $display("FAIL %s out: got %h expected %h", e.name, out, e.e_out);
                    end
                end
                if (e.chk_q) begin
                    n_tests += 2;
                    if (out_q !== e.e_out_q) begin
                        n_fail++;
                        $display("FAIL %s out_q: got %h expected %h", e.name, out_q, e.e_out_q);
                    end
                    if (sel_q !== e.e_sel_q) begin
                        n_fail++;
                        $display("FAIL %s sel_q: got %b expected %b", e.name, sel_q, e.e_sel_q);
                    end
                end
`ifdef MUX_2_PARITY_EN
                if (e.chk_par) begin
                    n_tests++;
                    if (par_q !== e.e_par) begin
                        n_fail++;
                        $display("FAIL %s par_q: got %b expected %b", e.name, par_q, e.e_par);
                    end
                end
`endif
            end
        end
    end

    task automatic expect_out(input string name, input logic [7:0] eo);
        exp_t e;
        e = '{name, 1'b1, eo, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0};
        sb.push_back(e);
        -> ev_push;
        #2;
    endtask

    task automatic expect_all(input string name, input logic [7:0] eo, input logic [7:0] eq,
                              input logic [1:0] es);
        exp_t e;
        e = '{name, 1'b1, eo, 1'b1, eq, es, 1'b0, 1'b0};
        sb.push_back(e);
        -> ev_push;
        #2;
    endtask

    task automatic expect_par(input string name, input logic ep);
        exp_t e;
        e = '{name, 1'b0, 8'h00, 1'b0, 8'h00, 2'b00, 1'b1, ep};
        sb.push_back(e);
        -> ev_push;
        #2;
    endtask

    logic [7:0] sel_out_exp [4] = '{8'h00, 8'hAB, 8'hCD, 8'h00};

    initial begin
        clr = 1'b1; en = 1'b0; sel = 2'b00;
        in0 = 8'h00; in1 = 8'h00; in2 = 8'h00; in3 = 8'h00;
        #1;
        expect_all("reset", 8'h00, 8'h00, 2'b00);
        @(negedge clk);
        clr = 1'b0;

        // Combinational selection over all four lanes
        in0 = 8'h00; in1 = 8'hAB; in2 = 8'hCD; in3 = 8'h00;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            expect_out($sformatf("sel%0d", i), sel_out_exp[i]);
        end
        en = 1'b0;
        @(posedge clk);
        expect_all("en0_hold_reset_val", 8'h00, 8'h00, 2'b00);

        // Enabled capture, then hold with en=0
        @(negedge clk);
        sel = 2'b01; in1 = 8'h5A; en = 1'b1;
        @(posedge clk);
        expect_all("capture_5A", 8'h5A, 8'h5A, 2'b01);
        @(negedge clk);
        en = 1'b0; in1 = 8'hFF;
        expect_all("hold_comb_FF", 8'hFF, 8'h5A, 2'b01);
        @(posedge clk);
        expect_all("hold_after_edge", 8'hFF, 8'h5A, 2'b01);

        // Asynchronous clear between edges; edges ignored while held
        @(negedge clk);
        #2;
        clr = 1'b1;
        expect_all("async_clr", 8'hFF, 8'h00, 2'b00);
        en = 1'b1; in1 = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            expect_all($sformatf("clr_held_edge%0d", i), 8'h3C, 8'h00, 2'b00);
        end
        @(negedge clk);
        clr = 1'b0;
        expect_all("clr_release_no_cap", 8'h3C, 8'h00, 2'b00);
        @(posedge clk);
        expect_all("cap_after_release", 8'h3C, 8'h3C, 2'b01);

        // Unknown select bit forces zero; lanes that an x1 select could resolve to are zero too
        @(negedge clk);
        en = 1'b0;
        in0 = 8'h00; in1 = 8'h00; in3 = 8'h00; in2 = 8'hC3;
        sel = 2'bx1;
        expect_out("sel_x1", 8'h00);
        sel = 2'b10;
        expect_out("sel_10_C3", 8'hC3);

        // Lane 3 capture
        in3 = 8'h81; sel = 2'b11; en = 1'b1;
        @(posedge clk);
        expect_all("capture_81", 8'h81, 8'h81, 2'b11);

`ifdef MUX_2_PARITY_EN
        @(negedge clk);
        in0 = 8'h07; sel = 2'b00;
        @(posedge clk);
        expect_par("par_07", 1'b1);
        @(negedge clk);
        in0 = 8'h03;
        @(posedge clk);
        expect_par("par_03", 1'b0);
        @(negedge clk);
        in0 = 8'h01;
        @(posedge clk);
        expect_par("par_01", 1'b1);
        @(negedge clk);
        clr = 1'b1;
        expect_par("par_clr", 1'b0);
        clr = 1'b0;
`endif

        #5;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
